sram_1r1w_init_array: RTL

//  Parametrised 1-read/1-write masked SRAM array model; successor to the single-port RW masked array macros.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_mask_merge.sv | 21 ++
 rtl/sram_1r1w_init_array.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the 1R1W masked SRAM array family.
package sram_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StDone
   } init_state_e;

   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned seg_w(input int unsigned width, input int unsigned segs);
      return width / segs;
   endfunction

endpackage

// File: rtl/sram_mask_merge.sv
// Per-segment merge of a new word over an old word, selected by a segment mask.
module sram_mask_merge
   import sram_pkg::*;
#(
   parameter int unsigned WIDTH     = 186,
   parameter int unsigned MASK_SEGS = 6
) (
   input  logic [WIDTH-1:0]     old_word_i,
   input  logic [WIDTH-1:0]     new_word_i,
   input  logic [MASK_SEGS-1:0] mask_i,
   output logic [WIDTH-1:0]     merged_o
);

   localparam int unsigned SEG_W = seg_w(WIDTH, MASK_SEGS);

   for (genvar i = 0; i < MASK_SEGS; i++) begin : g_seg
      assign merged_o[i*SEG_W +: SEG_W] = mask_i[i] ? new_word_i[i*SEG_W +: SEG_W]
                                                    : old_word_i[i*SEG_W +: SEG_W];
   end

endmodule

// File: rtl/sram_1r1w_init_array.sv
// 1-read/1-write masked SRAM array with write-to-read bypass, optional output
// register and a hardware clear sweep after reset or on request.
module sram_1r1w_init_array
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH         = 2048,
   parameter int unsigned WIDTH         = 186,
   parameter int unsigned MASK_SEGS     = 6,
   parameter int unsigned LATENCY       = 1,
   parameter int unsigned BYPASS        = 1,
   parameter int unsigned INIT_ON_RESET = 1,
   localparam int unsigned AW           = addr_w(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 init_req,
   output logic                 init_busy,
   output logic                 init_done,
   input  logic                 R0_en,
   input  logic [AW-1:0]        R0_addr,
   output logic                 R0_ready,
   output logic                 R0_valid,
   output logic [WIDTH-1:0]     R0_rdata,
   input  logic                 W0_en,
   input  logic [AW-1:0]        W0_addr,
   input  logic [MASK_SEGS-1:0] W0_mask,
   input  logic [WIDTH-1:0]     W0_data,
   output logic                 W0_ready
);

   if (WIDTH % MASK_SEGS != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of MASK_SEGS");
   end
   if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
      $error("LATENCY must be 1 or 2");
   end

   localparam init_state_e RESET_STATE = (INIT_ON_RESET != 0) ? StClear : StIdle;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   init_state_e   state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (init_req) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
         StClear: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign init_busy = (state_q == StClear);
   assign init_done = (state_q == StDone);
   assign R0_ready  = !init_busy;
   assign W0_ready  = !init_busy;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_acc, rd_acc, rd_in_range, bypass_hit;
   logic [WIDTH-1:0] wr_old, wr_merged, rd_word;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;

   assign wr_acc      = W0_en && !init_busy && (32'(W0_addr) < DEPTH);
   assign rd_acc      = R0_en && !init_busy;
   assign rd_in_range = 32'(R0_addr) < DEPTH;
   assign wr_old      = mem_q[W0_addr];

   // One merge serves both the array write and the same-address bypass read.
   sram_mask_merge #(
      .WIDTH     (WIDTH),
      .MASK_SEGS (MASK_SEGS)
   ) u_merge (
      .old_word_i (wr_old),
      .new_word_i (W0_data),
      .mask_i     (W0_mask),
      .merged_o   (wr_merged)
   );

   assign bypass_hit = (BYPASS != 0) && wr_acc && (R0_addr == W0_addr);
   assign rd_word    = !rd_in_range ? '0 : (bypass_hit ? wr_merged : mem_q[R0_addr]);

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = W0_addr;
      mem_wdata = wr_merged;
      if (init_busy) begin
         mem_we    = 1'b1;
         mem_waddr = cnt_q;
         mem_wdata = '0;
      end else if (wr_acc) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_data_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= rd_acc;
         if (rd_acc) begin
            s1_data_q <= rd_word;
         end
      end
   end

   if (LATENCY == 2) begin : g_lat2
      logic             s2_valid_q;
      logic [WIDTH-1:0] s2_data_q;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q <= s1_data_q;
            end
         end
      end

      assign R0_valid = s2_valid_q;
      assign R0_rdata = s2_data_q;
   end else begin : g_lat1
      assign R0_valid = s1_valid_q;
      assign R0_rdata = s1_data_q;
   end

endmodule
